// File: rtl/audio_dac_serializer_if.sv
// Stereo PCM frame stream from the sample source into the DAC serializer.
// Handshake: a frame transfers on every clock edge where s_valid and s_ready are both high.
interface audio_dac_serializer_if #(
  parameter int DATA_W = 16
);
  logic [2*DATA_W-1:0] s_data;
  logic                s_valid;
  logic                s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: buffers stereo frames in a small FIFO and shifts them out MSB-first,
// slaved to the codec's bit and word clocks, which are sampled in the clkin_50 domain.
module audio_dac_serializer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clkin_50,
  input  logic                          rst,
  audio_dac_serializer_if.slave         s,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          aud_bclk,
  input  logic                          aud_dac_lrck,
  output logic                          aud_dac_dat,
  output logic                          underrun,
  input  logic                          clr_underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W) + 1;
  localparam int FW = 2 * DATA_W;

  // [0],[1] synchronize; [2] holds the previous synchronized value for edge detection
  logic [2:0] bclk_sync;
  logic [2:0] lrck_sync;
  logic       bclk_fall;
  logic       lr_fall;
  logic       lr_rise;

  always_ff @(posedge clkin_50 or posedge rst) begin
    if (rst) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], aud_bclk};
      lrck_sync <= {lrck_sync[1:0], aud_dac_lrck};
    end
  end

  assign bclk_fall = bclk_sync[2] & ~bclk_sync[1];
  assign lr_fall   = lrck_sync[2] & ~lrck_sync[1];
  assign lr_rise   = ~lrck_sync[2] & lrck_sync[1];

  // Frame FIFO; pointers carry one extra wrap bit so full and empty are distinguishable
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          empty;
  logic          push;
  logic          pop;
  logic [FW-1:0] head;

  assign level      = wr_ptr - rd_ptr;
  assign empty      = (level == '0);
  assign s.s_ready  = (level != LW'(FIFO_DEPTH));
  assign fifo_level = level;
  assign push       = s.s_valid & s.s_ready;
  assign pop        = lr_fall & ~empty;
  assign head       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clkin_50) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= s.s_data;
    end
  end

  always_ff @(posedge clkin_50 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Serializer. Every lr_fall either is armed or arms, so it always starts a left slot.
  // An lrck edge wins over a coincident bclk_fall and leaves the data pin untouched,
  // which yields the one-BCLK MSB delay of I2S.
  logic [DATA_W-1:0] shreg;
  logic [FW-1:0]     frame_reg;
  logic [CW-1:0]     bitcnt;
  logic              armed;

  always_ff @(posedge clkin_50 or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      frame_reg   <= '0;
      bitcnt      <= CW'(DATA_W);
      armed       <= 1'b0;
      aud_dac_dat <= 1'b0;
    end else if (lr_fall) begin
      armed  <= 1'b1;
      bitcnt <= '0;
      if (!empty) begin
        frame_reg <= head;
        shreg     <= head[FW-1:DATA_W];
      end else begin
        frame_reg <= '0;
        shreg     <= '0;
      end
    end else if (lr_rise) begin
      if (armed) begin
        shreg  <= frame_reg[DATA_W-1:0];
        bitcnt <= '0;
      end
    end else if (bclk_fall && armed) begin
      if (bitcnt < CW'(DATA_W)) begin
        aud_dac_dat <= shreg[DATA_W-1];
        shreg       <= {shreg[DATA_W-2:0], 1'b0};
        bitcnt      <= bitcnt + 1'b1;
      end else begin
        aud_dac_dat <= 1'b0;
      end
    end
  end

  // A new underrun outranks a clear arriving in the same cycle
  always_ff @(posedge clkin_50 or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (lr_fall && empty) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: drives codec clocks slot by slot and checks every serial
// bit, FIFO level/ready and the underrun flag against a frame-queue model.
module tb_audio_dac_serializer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int H      = 4;  // clkin_50 cycles per BCLK half period

  logic        clkin_50 = 1'b0;
  logic        rst;
  logic [2:0]  fifo_level;
  logic        aud_bclk;
  logic        aud_dac_lrck;
  logic        aud_dac_dat;
  logic        underrun;
  logic        clr_underrun;

  int n_checks = 0;
  int n_errors = 0;

  // Model: buffered frames, the frame currently being played, armed and underrun state
  logic [31:0] exp_q[$];
  logic [31:0] m_frame;
  bit          m_armed;
  bit          m_underrun;
  bit          m_dat;

  always #10 clkin_50 = ~clkin_50;

  audio_dac_serializer_if #(.DATA_W(DATA_W)) bus ();

  audio_dac_serializer #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clkin_50     (clkin_50),
    .rst          (rst),
    .s            (bus),
    .fifo_level   (fifo_level),
    .aud_bclk     (aud_bclk),
    .aud_dac_lrck (aud_dac_lrck),
    .aud_dac_dat  (aud_dac_dat),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkin_50);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_frame    = '0;
    m_armed    = 1'b0;
    m_underrun = 1'b0;
    m_dat      = 1'b0;
  endtask

  task automatic check_status();
    check("level", 32'(fifo_level), 32'(exp_q.size()));
    check("ready", 32'(bus.s_ready), 32'(exp_q.size() < DEPTH));
    check("underrun", 32'(underrun), 32'(m_underrun));
  endtask

  // Leaves s_valid high so consecutive calls form a back-to-back burst
  task automatic push_frame(input logic [31:0] d);
    bit ok;
    ok = (exp_q.size() < DEPTH);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    check("push_ready", 32'(bus.s_ready), 32'(ok));
    if (ok) exp_q.push_back(d);
    tick(1);
    check("push_level", 32'(fifo_level), 32'(exp_q.size()));
  endtask

  task automatic idle_bus();
    bus.s_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_underrun = 1'b1;
    tick(1);
    clr_underrun = 1'b0;
    m_underrun   = 1'b0;
    tick(1);
    check("clr_underrun", 32'(underrun), 32'(m_underrun));
  endtask

  // One LRCK slot of nb BCLKs; the LRCK edge coincides with BCLK fall #0.
  // clr_hit/push_hit land in the same clkin_50 cycle the DUT acts on the LRCK edge.
  // rst_after >= 1 asserts reset right after that many data bits and abandons the slot.
  task automatic run_slot(input bit is_left, input int nb, input int rst_after,
                          input bit clr_hit, input bit push_hit, input logic [31:0] push_d);
    logic [15:0] word;
    bit          e;
    bit          push_ok;
    if (is_left) begin
      push_ok = push_hit && (exp_q.size() < DEPTH);
      m_armed = 1'b1;
      if (exp_q.size() > 0) begin
        m_frame = exp_q.pop_front();
        if (clr_hit) m_underrun = 1'b0;
      end else begin
        m_frame    = '0;
        m_underrun = 1'b1;
      end
      if (push_ok) exp_q.push_back(push_d);
      word = m_frame[31:16];
    end else begin
      word = m_armed ? m_frame[15:0] : 16'h0;
    end
    for (int k = 0; k < nb; k++) begin
      aud_bclk = 1'b1;
      tick(H);
      aud_bclk = 1'b0;
      if (k == 0) aud_dac_lrck = !is_left;
      if (k == 0 && (clr_hit || push_hit)) begin
        tick(2);
        clr_underrun = clr_hit;
        if (push_hit) begin
          bus.s_valid = 1'b1;
          bus.s_data  = push_d;
        end
        tick(1);
        clr_underrun = 1'b0;
        bus.s_valid  = 1'b0;
        tick(H - 3);
      end else begin
        tick(H);
      end
      if (k == 0) e = m_dat;
      else if (k <= DATA_W) e = word[DATA_W-k];
      else e = 1'b0;
      m_dat = e;
      check(is_left ? "left_bit" : "right_bit", 32'(aud_dac_dat), 32'(e));
      if (k == rst_after) begin
        rst = 1'b1;
        #1;
        check("rst_dat", 32'(aud_dac_dat), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(bus.s_ready), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        model_reset();
        tick(3);
        rst = 1'b0;
        tick(2);
        return;
      end
    end
    check_status();
  endtask

  task automatic run_frame(input int nb);
    run_slot(1'b1, nb, -1, 1'b0, 1'b0, 32'h0);
    run_slot(1'b0, nb, -1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst          = 1'b1;
    aud_bclk     = 1'b0;
    aud_dac_lrck = 1'b1;
    clr_underrun = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    model_reset();
    tick(3);
    check("reset_dat", 32'(aud_dac_dat), 32'd0);
    check_status();
    rst = 1'b0;
    tick(4);

    // Known pattern through both slots
    push_frame(32'hA5F0_0F5A);
    idle_bus();
    run_frame(32);

    // Fill past capacity with no LRCK activity, then one pop
    for (int i = 0; i < 5; i++) push_frame($urandom);
    idle_bus();
    tick(1);
    check_status();
    run_slot(1'b1, 32, -1, 1'b0, 1'b0, 32'h0);
    run_slot(1'b0, 32, -1, 1'b0, 1'b0, 32'h0);

    // Drain, underrun, sticky after refill, clear, clear colliding with a new underrun
    for (int i = 0; i < 3; i++) run_frame(32);
    run_frame(32);
    push_frame($urandom);
    idle_bus();
    run_frame(32);
    check("underrun_sticky", 32'(underrun), 32'd1);
    pulse_clr();
    run_slot(1'b1, 32, -1, 1'b1, 1'b0, 32'h0);
    run_slot(1'b0, 32, -1, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a left slot, then clean restart at the next LRCK fall
    push_frame($urandom);
    push_frame($urandom);
    idle_bus();
    run_slot(1'b1, 32, 7, 1'b0, 1'b0, 32'h0);
    push_frame(32'h1234_ABCD);
    push_frame($urandom);
    idle_bus();
    run_slot(1'b0, 32, -1, 1'b0, 1'b0, 32'h0);
    run_frame(32);

    // Simultaneous push and pop at level 2 over random frames and slot lengths
    while (exp_q.size() < 2) push_frame($urandom);
    idle_bus();
    for (int i = 0; i < 16; i++) begin
      int nb;
      nb = $urandom_range(18, 32);
      while (exp_q.size() < 2) push_frame($urandom);
      idle_bus();
      run_slot(1'b1, nb, -1, 1'b0, 1'b1, $urandom);
      run_slot(1'b0, nb, -1, 1'b0, 1'b0, 32'h0);
    end

    // Short slots: bits past fall #11 are dropped at the next LRCK edge
    for (int i = 0; i < 3; i++) push_frame($urandom);
    idle_bus();
    for (int i = 0; i < 3; i++) run_frame(12);
    run_frame(32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
